// File: rtl/alu_seq_core.sv
// alu_seq_core: sequential unsigned ALU with two operand registers.
//   ADD/SUB complete at the start edge; MUL (shift-add) and DIV (restoring)
//   iterate once per edge for WIDTH edges. start/busy/done handshake.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   in_a, in_b      operand data, captured by load_a/load_b while idle
//   op              00 ADD, 01 SUB, 10 MUL, 11 DIV (sampled with start)
//   start           begin an operation (only accepted while idle)
//   busy            high from the accepting edge until the done cycle ends
//   done            one-cycle pulse, result/flag just written
//   result, flag    registered outputs, held until the next completion
module alu_seq_core #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               load_a,
  input  logic               load_b,
  input  logic [1:0]         op,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               flag
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] reg_a, reg_b;
  // Shared work registers: hi = accumulator / partial remainder,
  // lo = multiplier / dividend-becoming-quotient, mdr = multiplicand / divisor.
  logic [WIDTH-1:0] hi, lo, mdr;
  logic             is_div;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   add_sum, sub_diff;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic             multicycle;

  assign add_sum  = {1'b0, reg_a} + {1'b0, reg_b};
  assign sub_diff = {1'b0, reg_a} - {1'b0, reg_b};  // bit WIDTH is the borrow

  // One multiply step: conditionally add, then shift {carry,hi,lo} right.
  assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mdr} : '0);
  // One divide step: shift next dividend bit into the remainder, trial-subtract.
  assign div_shift = {hi, lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mdr};
  assign div_ge    = (div_shift >= {1'b0, mdr});

  always_comb begin
    hi_nxt = mul_sum[WIDTH:1];
    lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
    if (is_div) begin
      hi_nxt = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], div_ge};
    end
  end

  assign multicycle = (op == OP_MUL) || ((op == OP_DIV) && (reg_b != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = multicycle ? RUN : DONE;
      RUN:  if (cnt == '0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a  <= '0;
      reg_b  <= '0;
      hi     <= '0;
      lo     <= '0;
      mdr    <= '0;
      is_div <= 1'b0;
      cnt    <= '0;
      result <= '0;
      flag   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Operation below reads the pre-edge reg_a/reg_b, so a same-cycle
          // load only affects later operations.
          if (load_a) reg_a <= in_a;
          if (load_b) reg_b <= in_b;
          if (start) begin
            case (op)
              OP_ADD: begin
                result <= {{(WIDTH-1){1'b0}}, add_sum};
                flag   <= add_sum[WIDTH];
              end
              OP_SUB: begin
                result <= {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
                flag   <= sub_diff[WIDTH];
              end
              OP_MUL: begin
                hi     <= '0;
                lo     <= reg_b;
                mdr    <= reg_a;
                is_div <= 1'b0;
                cnt    <= CW'(WIDTH-1);
              end
              default: begin
                if (reg_b == '0) begin
                  result <= {reg_a, {WIDTH{1'b1}}};
                  flag   <= 1'b1;
                end else begin
                  hi     <= '0;
                  lo     <= reg_a;
                  mdr    <= reg_b;
                  is_div <= 1'b1;
                  cnt    <= CW'(WIDTH-1);
                end
              end
            endcase
          end
        end
        RUN: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            result <= {hi_nxt, lo_nxt};
            flag   <= is_div ? 1'b0 : (hi_nxt != '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
